// File: rtl/axi_slave_mem_if.sv
// AXI4 slave-side bundle for axi_slave_mem: AW/W/B write channels and AR/R read channels.
interface axi_slave_mem_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
) ();
  logic [ID_WIDTH-1:0]     S_AXI_AWID;
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [7:0]              S_AXI_AWLEN;
  logic [1:0]              S_AXI_AWBURST;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WLAST;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [ID_WIDTH-1:0]     S_AXI_BID;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ID_WIDTH-1:0]     S_AXI_ARID;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [7:0]              S_AXI_ARLEN;
  logic [1:0]              S_AXI_ARBURST;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [ID_WIDTH-1:0]     S_AXI_RID;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RLAST;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI4 INCR-burst slave memory, independent read/write engines, one outstanding burst each.
// AXI_SLV_STALL_EN adds periodic WREADY / R-beat stalls from free-running 2-bit counters.
module axi_slave_mem #(
  parameter int                    ID_WIDTH   = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 256,
  parameter int                    MEM_DEPTH  = 65536,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h40000000
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  axi_slave_mem_if.slave   s_axi
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int MAW   = $clog2(MEM_DEPTH);
  localparam int XA    = ADDR_WIDTH + 1;   // extra bit keeps the incrementing address from wrapping into range
  localparam logic [XA-1:0] XBASE  = {1'b0, BASE_ADDR};
  localparam logic [XA-1:0] XDEPTH = XA'(MEM_DEPTH);
  localparam logic [XA-1:0] XSTEP  = XA'(BYTES);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  function automatic logic in_range(input logic [XA-1:0] a);
    logic [XA-1:0] off;
    off = (a - XBASE) >> SHIFT;
    return (a >= XBASE) && (off < XDEPTH);
  endfunction

  function automatic logic [MAW-1:0] widx(input logic [XA-1:0] a);
    logic [XA-1:0] off;
    off = (a - XBASE) >> SHIFT;
    return MAW'(off);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t              w_state, w_next;
  logic [XA-1:0]         w_addr, w_addr_n;
  logic [7:0]            w_len, w_len_n, w_cnt, w_cnt_n;
  logic [ID_WIDTH-1:0]   w_id, w_id_n, bid, bid_n;
  logic                  w_inc, w_inc_n, w_dec, w_dec_n, w_lerr, w_lerr_n;
  logic                  awready, wready, bvalid, bvalid_n, mem_we, w_beat_last, w_stall_n;
  logic [1:0]            bresp, bresp_n;

  r_state_t              r_state, r_next;
  logic [XA-1:0]         r_addr, r_addr_n;
  logic [7:0]            r_len, r_len_n, r_cnt, r_cnt_n;
  logic [ID_WIDTH-1:0]   r_id, r_id_n;
  logic                  r_inc, r_inc_n, arready, rvalid, rvalid_n, rlast, rlast_n, present, r_stall_n;
  logic [DATA_WIDTH-1:0] rdata, rdata_n;
  logic [1:0]            rresp, rresp_n;

`ifdef AXI_SLV_STALL_EN
  logic [1:0] w_stall_cnt, r_stall_cnt;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_stall_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      w_stall_cnt <= w_stall_cnt + 2'd1;
      r_stall_cnt <= r_stall_cnt + 2'd1;
    end
  end
  // Ready/valid are registered, so look one count ahead to land the stall on count 3.
  assign w_stall_n = (w_stall_cnt == 2'd2);
  assign r_stall_n = (r_stall_cnt == 2'd2);
`else
  assign w_stall_n = 1'b0;
  assign r_stall_n = 1'b0;
`endif

  always_comb begin
    w_next = w_state;  w_addr_n = w_addr;  w_len_n = w_len;  w_cnt_n = w_cnt;
    w_id_n = w_id;     w_inc_n = w_inc;    w_dec_n = w_dec;  w_lerr_n = w_lerr;
    bvalid_n = bvalid; bid_n = bid;        bresp_n = bresp;
    mem_we = 1'b0;     w_beat_last = 1'b0;
    case (w_state)
      W_IDLE: if (s_axi.S_AXI_AWVALID && awready) begin
        w_next   = W_DATA;
        w_addr_n = {1'b0, s_axi.S_AXI_AWADDR};
        w_len_n  = s_axi.S_AXI_AWLEN;
        w_cnt_n  = '0;
        w_id_n   = s_axi.S_AXI_AWID;
        w_inc_n  = (s_axi.S_AXI_AWBURST == 2'b01);
        w_dec_n  = 1'b0;
        w_lerr_n = 1'b0;
      end
      W_DATA: if (s_axi.S_AXI_WVALID && wready) begin
        // The beat count, not WLAST, closes the burst; a WLAST disagreement only flags SLVERR.
        w_beat_last = (w_cnt == w_len);
        mem_we      = in_range(w_addr) && w_inc;
        w_dec_n     = w_dec || !in_range(w_addr);
        w_lerr_n    = w_lerr || (s_axi.S_AXI_WLAST != w_beat_last);
        w_cnt_n     = w_cnt + 8'd1;
        w_addr_n    = w_addr + XSTEP;
        if (w_beat_last) begin
          w_next   = W_RESP;
          bvalid_n = 1'b1;
          bid_n    = w_id;
          bresp_n  = w_dec_n ? 2'b11 : (!w_inc || w_lerr_n) ? 2'b10 : 2'b00;
        end
      end
      W_RESP: if (s_axi.S_AXI_BREADY) begin
        w_next   = W_IDLE;
        bvalid_n = 1'b0;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE; w_addr <= '0; w_len <= '0; w_cnt <= '0; w_id <= '0;
      w_inc <= 1'b0; w_dec <= 1'b0; w_lerr <= 1'b0;
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bid <= '0; bresp <= '0;
    end else begin
      w_state <= w_next; w_addr <= w_addr_n; w_len <= w_len_n; w_cnt <= w_cnt_n; w_id <= w_id_n;
      w_inc <= w_inc_n; w_dec <= w_dec_n; w_lerr <= w_lerr_n;
      awready <= (w_next == W_IDLE);
      wready  <= (w_next == W_DATA) && !w_stall_n;
      bvalid  <= bvalid_n; bid <= bid_n; bresp <= bresp_n;
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (s_axi.S_AXI_WSTRB[i]) mem[widx(w_addr)][8*i +: 8] <= s_axi.S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    r_next = r_state;  r_addr_n = r_addr;  r_len_n = r_len;  r_cnt_n = r_cnt;
    r_id_n = r_id;     r_inc_n = r_inc;    rvalid_n = rvalid; rdata_n = rdata;
    rresp_n = rresp;   rlast_n = rlast;    present = 1'b0;
    case (r_state)
      R_IDLE: if (s_axi.S_AXI_ARVALID && arready) begin
        r_next   = R_DATA;
        r_addr_n = {1'b0, s_axi.S_AXI_ARADDR};
        r_len_n  = s_axi.S_AXI_ARLEN;
        r_cnt_n  = '0;
        r_id_n   = s_axi.S_AXI_ARID;
        r_inc_n  = (s_axi.S_AXI_ARBURST == 2'b01);
        present  = 1'b1;
      end
      R_DATA: if (rvalid && s_axi.S_AXI_RREADY) begin
        if (r_cnt == r_len) begin
          r_next   = R_IDLE;
          rvalid_n = 1'b0;
        end else begin
          r_cnt_n  = r_cnt + 8'd1;
          r_addr_n = r_addr + XSTEP;
          present  = 1'b1;
        end
      end else if (!rvalid) begin
        present = 1'b1;
      end
      default: r_next = R_IDLE;
    endcase
    // Memory is sampled at the edge that registers the beat, so a same-cycle write is not seen.
    if (present) begin
      if (r_stall_n) begin
        rvalid_n = 1'b0;
      end else begin
        rvalid_n = 1'b1;
        rlast_n  = (r_cnt_n == r_len_n);
        rresp_n  = !in_range(r_addr_n) ? 2'b11 : !r_inc_n ? 2'b10 : 2'b00;
        rdata_n  = (in_range(r_addr_n) && r_inc_n) ? mem[widx(r_addr_n)] : '0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= R_IDLE; r_addr <= '0; r_len <= '0; r_cnt <= '0; r_id <= '0; r_inc <= 1'b0;
      arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= '0; rlast <= 1'b0;
    end else begin
      r_state <= r_next; r_addr <= r_addr_n; r_len <= r_len_n; r_cnt <= r_cnt_n; r_id <= r_id_n;
      r_inc <= r_inc_n;
      arready <= (r_next == R_IDLE);
      rvalid  <= rvalid_n; rdata <= rdata_n; rresp <= rresp_n; rlast <= rlast_n;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BID     = bid;
  assign s_axi.S_AXI_BRESP   = bresp;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RID     = r_id;
  assign s_axi.S_AXI_RDATA   = rdata;
  assign s_axi.S_AXI_RRESP   = rresp;
  assign s_axi.S_AXI_RLAST   = rlast;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: reference word array, expected R beats and B responses queued at issue.
module tb_axi_slave_mem;
  localparam int          IDW   = 4;
  localparam int          AW    = 32;
  localparam int          DW    = 256;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h40000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_slave_mem_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_slave_mem #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(bus)
  );

  typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; logic [IDW-1:0] id; } rbeat_t;
  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } bexp_t;

  logic [DW-1:0] model [DEPTH];
  rbeat_t        rq[$];
  bexp_t         bq[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  logic [DW-1:0] ones   = '1;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ok_addr(input longint a);
    return (a >= longint'(BASE)) && (((a - longint'(BASE)) / 32) < DEPTH);
  endfunction

  function automatic int widx(input longint a);
    return int'((a - longint'(BASE)) / 32);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [IDW-1:0] id, input longint addr, input int len, input logic [1:0] burst,
                    input logic [DW-1:0] d0, input logic [31:0] strb, input int early, input int hold);
    logic          hs;
    logic          dec;
    logic [1:0]    resp;
    logic [DW-1:0] d;
    longint        a;
    int            t;
    bexp_t         e;
    dec = 1'b0;
    bus.S_AXI_AWID = id; bus.S_AXI_AWADDR = addr[31:0]; bus.S_AXI_AWLEN = len[7:0];
    bus.S_AXI_AWBURST = burst; bus.S_AXI_AWVALID = 1'b1;
    t = 0;
    do begin
      @(negedge clk); hs = bus.S_AXI_AWREADY; t++; tick();
    end while (!hs && t < 50);
    bus.S_AXI_AWVALID = 1'b0;
    if (!hs) begin chk("aw_timeout", 0, 1); return; end
    for (int k = 0; k <= len; k++) begin
      d = d0 + DW'(k);
      a = addr + 32 * k;
      bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = strb;
      bus.S_AXI_WLAST = (k == len) || (k == early); bus.S_AXI_WVALID = 1'b1;
      t = 0;
      do begin
        @(negedge clk); hs = bus.S_AXI_WREADY;
`ifndef AXI_SLV_STALL_EN
        if (k == 0 && t == 0) chk("wready_after_aw", hs, 1);
`endif
        t++; tick();
      end while (!hs && t < 50);
      if (!hs) begin chk("w_timeout", 0, 1); bus.S_AXI_WVALID = 1'b0; return; end
      if (ok_addr(a) && burst == 2'b01) begin
        for (int b = 0; b < 32; b++) if (strb[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
      end
      dec = dec || !ok_addr(a);
    end
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
    resp = dec ? 2'b11 : (burst != 2'b01 || (early >= 0 && early != len)) ? 2'b10 : 2'b00;
    bq.push_back('{id: id, resp: resp});
    t = 0;
    @(negedge clk);
    while (!bus.S_AXI_BVALID && t < 20) begin @(negedge clk); t++; end
    if (!bus.S_AXI_BVALID) begin chk("b_timeout", 0, 1); return; end
    for (int h = 0; h < hold; h++) begin
      chk("bvalid_held", bus.S_AXI_BVALID, 1);
      @(negedge clk);
    end
    bus.S_AXI_BREADY = 1'b1;
    e = bq.pop_front();
    chk("bid", bus.S_AXI_BID, e.id);
    chk("bresp", bus.S_AXI_BRESP, e.resp);
    tick();
    bus.S_AXI_BREADY = 1'b0;
    @(negedge clk);
    chk("awready_after_b", bus.S_AXI_AWREADY, 1);
  endtask

  task automatic rd(input logic [IDW-1:0] id, input longint addr, input int len, input logic [1:0] burst,
                    input logic toggle, input int abort_at);
    logic          hs;
    logic          stalled;
    logic [DW-1:0] held;
    longint        a;
    int            t;
    int            got;
    rbeat_t        e;
    for (int k = 0; k <= len; k++) begin
      a = addr + 32 * k;
      e.data = (ok_addr(a) && burst == 2'b01) ? model[widx(a)] : '0;
      e.resp = !ok_addr(a) ? 2'b11 : (burst != 2'b01) ? 2'b10 : 2'b00;
      e.last = (k == len);
      e.id   = id;
      rq.push_back(e);
    end
    bus.S_AXI_ARID = id; bus.S_AXI_ARADDR = addr[31:0]; bus.S_AXI_ARLEN = len[7:0];
    bus.S_AXI_ARBURST = burst; bus.S_AXI_ARVALID = 1'b1;
    t = 0;
    do begin
      @(negedge clk); hs = bus.S_AXI_ARREADY; t++; tick();
    end while (!hs && t < 50);
    bus.S_AXI_ARVALID = 1'b0;
    if (!hs) begin chk("ar_timeout", 0, 1); rq.delete(); return; end
    bus.S_AXI_RREADY = 1'b1;
    got = 0; t = 0; stalled = 1'b0;
    while (got <= len && t < 300) begin
      @(negedge clk);
`ifndef AXI_SLV_STALL_EN
      if (t == 0) chk("rvalid_after_ar", bus.S_AXI_RVALID, 1);
`endif
      t++;
      if (stalled) begin
        chk("rvalid_kept", bus.S_AXI_RVALID, 1);
        chk("rdata_stable", bus.S_AXI_RDATA, held);
        stalled = 1'b0;
      end
      if (bus.S_AXI_RVALID) begin
        if (bus.S_AXI_RREADY) begin
          e = rq.pop_front();
          chk("rdata", bus.S_AXI_RDATA, e.data);
          chk("rresp", bus.S_AXI_RRESP, e.resp);
          chk("rlast", bus.S_AXI_RLAST, e.last);
          chk("rid", bus.S_AXI_RID, e.id);
          got++;
        end else begin
          held = bus.S_AXI_RDATA;
          stalled = 1'b1;
        end
      end
      tick();
      if (toggle) bus.S_AXI_RREADY = ~bus.S_AXI_RREADY;
      if (abort_at >= 0 && got == abort_at) begin
        bus.S_AXI_RREADY = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rvalid_in_reset", bus.S_AXI_RVALID, 0);
        chk("arready_in_reset", bus.S_AXI_ARREADY, 0);
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("arready_at_release", bus.S_AXI_ARREADY, 0);
        @(negedge clk);
        chk("arready_after_release", bus.S_AXI_ARREADY, 1);
        chk("rvalid_after_release", bus.S_AXI_RVALID, 0);
        rq.delete();
        tick();
        return;
      end
    end
    bus.S_AXI_RREADY = 1'b0;
    if (got <= len) begin chk("r_timeout", got, len + 1); rq.delete(); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp5;
    bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWBURST = '0;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0;
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0; bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0;
    bus.S_AXI_ARLEN = '0; bus.S_AXI_ARBURST = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_awready", bus.S_AXI_AWREADY, 0);
    chk("rst_wready", bus.S_AXI_WREADY, 0);
    chk("rst_bvalid", bus.S_AXI_BVALID, 0);
    chk("rst_bresp", bus.S_AXI_BRESP, 0);
    chk("rst_arready", bus.S_AXI_ARREADY, 0);
    chk("rst_rvalid", bus.S_AXI_RVALID, 0);
    chk("rst_rdata", bus.S_AXI_RDATA, 0);
    chk("rst_rlast", bus.S_AXI_RLAST, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("awready_at_release", bus.S_AXI_AWREADY, 0);
    @(negedge clk);
    chk("awready_after_release", bus.S_AXI_AWREADY, 1);
    chk("arready_after_release0", bus.S_AXI_ARREADY, 1);
    tick();

    // basic 4-beat write then readback
    wr(4'h1, BASE, 3, 2'b01, '0, 32'hFFFF_FFFF, -1, 0); tick();
    rd(4'h2, BASE, 3, 2'b01, 1'b0, -1);

    // byte strobes on word 5, read both aligned and unaligned
    wr(4'h3, BASE + 5 * 32, 0, 2'b01, ones, 32'hFFFF_FFFF, -1, 0); tick();
    wr(4'h3, BASE + 5 * 32, 0, 2'b01, '0, 32'h0000_0001, -1, 0); tick();
    exp5 = ones;
    exp5[7:0] = 8'h00;
    chk("model_word5", model[5], exp5);
    rd(4'h4, BASE + 5 * 32, 0, 2'b01, 1'b0, -1);
    rd(4'h4, BASE + 5 * 32 + 7, 0, 2'b01, 1'b0, -1);

    // decode errors: past the end, straddling the end, below base
    wr(4'h5, BASE + DEPTH * 32, 0, 2'b01, 256'hDEAD, 32'hFFFF_FFFF, -1, 0); tick();
    rd(4'h5, BASE + DEPTH * 32, 0, 2'b01, 1'b0, -1);
    wr(4'h6, BASE + (DEPTH - 1) * 32, 1, 2'b01, 256'd77, 32'hFFFF_FFFF, -1, 0); tick();
    rd(4'h6, BASE + (DEPTH - 1) * 32, 1, 2'b01, 1'b0, -1);
    rd(4'h6, BASE - 32, 0, 2'b01, 1'b0, -1);

    // non-INCR burst is consumed but not written; non-INCR read returns zeros
    wr(4'h7, BASE + 20 * 32, 3, 2'b01, 256'd100, 32'hFFFF_FFFF, -1, 0); tick();
    wr(4'h7, BASE + 20 * 32, 3, 2'b10, 256'd200, 32'hFFFF_FFFF, -1, 0); tick();
    rd(4'h7, BASE + 20 * 32, 3, 2'b01, 1'b0, -1);
    rd(4'h8, BASE + 20 * 32, 1, 2'b10, 1'b0, -1);

    // early WLAST: all beats land, response is SLVERR
    wr(4'h9, BASE + 30 * 32, 3, 2'b01, 256'd300, 32'hFFFF_FFFF, 1, 0); tick();
    rd(4'h9, BASE + 30 * 32, 3, 2'b01, 1'b0, -1);

    // concurrent throttled read and held-off write response
    wr(4'hA, BASE + 100 * 32, 7, 2'b01, 256'd1000, 32'hFFFF_FFFF, -1, 0); tick();
    fork
      wr(4'hB, BASE + 40 * 32, 3, 2'b01, 256'd500, 32'hFFFF_FFFF, -1, 5);
      rd(4'hC, BASE + 100 * 32, 7, 2'b01, 1'b1, -1);
    join
    tick();
    rd(4'hC, BASE + 40 * 32, 3, 2'b01, 1'b0, -1);

    // reset mid-burst, then the same burst again
    rd(4'hD, BASE + 100 * 32, 7, 2'b01, 1'b0, 3);
    rd(4'hE, BASE + 100 * 32, 7, 2'b01, 1'b0, -1);

    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_slave_mem.md
Name:
axi_slave_mem

Overview:
AXI4 full-protocol slave memory that answers the accelerator's AXI master: serves IFM/weight burst reads and absorbs OFM burst writes into an internal word array; used as the DDR-side responder in system benches and as an on-chip scratch target. Independent read and write engines, one outstanding transaction per direction, INCR bursts of 1..256 beats at full data width.

Parameters:
ID_WIDTH, 4, AXI ID width for AW/B/AR/R
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 256, AXI data width (power of 2, >=32)
MEM_DEPTH, 65536, number of DATA_WIDTH-bit words in the array
BASE_ADDR, 32'h40000000, byte address that maps to word 0

Ports:
ACLK  in  1  clock; single clock domain, all logic on rising edge
ARESETN  in  1  reset, asynchronous, active-low
S_AXI_AWID  in  ID_WIDTH  write ID
S_AXI_AWADDR  in  ADDR_WIDTH  write burst start byte address
S_AXI_AWLEN  in  8  beats-1
S_AXI_AWBURST  in  2  burst type; only INCR (2'b01) supported
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BID  out  ID_WIDTH  echoed AWID
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARID  in  ID_WIDTH  read ID
S_AXI_ARADDR  in  ADDR_WIDTH  read burst start byte address
S_AXI_ARLEN  in  8  beats-1
S_AXI_ARBURST  in  2  burst type
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RID  out  ID_WIDTH  echoed ARID
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready

Behaviour:
- Reset: all READY/VALID, BID, BRESP, RID, RDATA, RRESP, RLAST = 0; both FSMs to IDLE; memory contents NOT reset. ARESETN low mid-burst aborts the burst, no B/R completion issued; AWREADY/ARREADY rise the first cycle after release.
- Addressing: word = (ADDR-BASE_ADDR) >> log2(DATA_WIDTH/8), +1 per beat, unaligned low bits ignored; AxLEN+1 beats; AxSIZE implied full width.
- Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE: AWREADY=1 only in W_IDLE. AW handshake in cycle T -> WREADY=1 from T+1. Each WVALID&&WREADY beat writes bytes with WSTRB[i]=1. After AWLEN+1 beats WREADY=0 and BVALID=1 next cycle, BID=AWID, held until BREADY; AWREADY=1 the cycle after the B handshake. Beat count, not WLAST, ends the burst.
- Write errors, priority: beat address < BASE_ADDR or word >= MEM_DEPTH -> that beat dropped, BRESP=2'b11 (DECERR); else AWBURST!=INCR -> all beats consumed, none written, 2'b10 (SLVERR); else WLAST mismatch (high early or low on final beat) -> data written, SLVERR; else 2'b00.
- Read FSM R_IDLE->R_DATA->R_IDLE: ARREADY=1 only in R_IDLE. AR handshake at T -> RVALID=1 at T+1 with beat 0. RDATA/RRESP/RLAST/RID stable while RVALID&&!RREADY. Next beat presented the cycle after each handshake (1 beat/cycle at full throughput). RLAST=1 on beat ARLEN only. ARREADY=1 the cycle after the final handshake. Out-of-range beat -> RDATA=0, RRESP=DECERR; non-INCR -> every beat RDATA=0, SLVERR; RID=ARID on all beats.
- Concurrency: read and write engines fully independent, may run simultaneously. Same word read and written in the same cycle -> read returns old data (read-first).

Optional Feature:
AXI_SLV_STALL_EN: when defined, a free-running 2-bit counter per engine forces WREADY=0 in W_DATA, and blocks presenting a new R beat, whenever the counter == 3 (a beat already valid is never withdrawn). Without the macro: no stalls, full throughput as above.

Test Plan:
- AW addr 0x40000000 len 3, WDATA k=0..3, WSTRB all 1s -> BRESP 0 after 4 beats; AR same addr len 3 -> RDATA 0,1,2,3, RLAST on 4th beat, RRESP 0.
- Write word 5 with 0xFFFF..., then WSTRB=32'h0000_0001 with data 0 -> readback byte0=0x00, rest 0xFF.
- AWADDR=0x40000000+MEM_DEPTH*32, len 0 -> BRESP 2'b11, memory unchanged; AR same -> RDATA 0, RRESP 2'b11; AWBURST=2'b10 -> SLVERR, nothing written; WLAST early on beat 1 of len 3 -> SLVERR, all 4 beats written.
- Read len 7 with RREADY toggled 1/0 each cycle and BREADY held low 5 cycles during a concurrent write -> RDATA stable while stalled, all 8 beats in order, BVALID held 5 cycles; ARESETN pulsed low at read beat 3 -> RVALID=0, ARREADY=1 the cycle after release, next burst correct.
